// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle single-precision adder sequencer with valid/ready
// handshakes on both sides. The operands are ordered by magnitude, and the
// smaller one is aligned. The pair is then added or subtracted, normalized
// and rounded to nearest-even.
// Optional build macro: FP_ADD_SEQ_FAST_ALIGN_EN. When it is defined, ALIGN
// does one barrel shift in a single cycle instead of a 1-bit-per-cycle shift.

package definitions;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mnt;
  } Float32;
endpackage

// Orders two floats by magnitude and reports their exponent difference.
module float_cmp
  import definitions::*;
(
  input  Float32     a,
  input  Float32     b,
  output Float32     gt,
  output Float32     lt,
  output logic [7:0] e_dif
);

  logic w_a_ge;

  // Magnitude compare on {exp, mnt}; ties resolve to a as the larger operand.
  always_comb begin
    w_a_ge = ({a.exp, a.mnt} >= {b.exp, b.mnt});
    gt     = w_a_ge ? a : b;
    lt     = w_a_ge ? b : a;
    e_dif  = gt.exp - lt.exp;
  end

endmodule

module fp_add_seq
  import definitions::*;
#(
  parameter int unsigned MAX_ALIGN = 27
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  Float32 a,
  input  Float32 b,
  output logic   out_valid,
  input  logic   out_ready,
  output Float32 result,
  output logic   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  Float32      r_a;
  Float32      r_b;
  Float32      r_result;

  // Working mantissas: [27] carry, [26] hidden, [25:3] fraction, [2:0] G/R/S.
  logic [27:0] r_mg;
  logic [27:0] r_ml;
  logic [9:0]  r_exp;
  logic        r_sign;
  logic        r_sub;
  logic [7:0]  r_cnt;

  Float32      w_gt;
  Float32      w_lt;
  logic [7:0]  w_edif;
  logic [7:0]  w_cnt_load;
  logic        w_gt_zero;

  logic        w_align_done;
  logic [27:0] w_ml_aligned;

  logic        w_norm_zero;
  logic        w_norm_carry;
  logic        w_norm_low;
  logic        w_carry_ovf;
  logic        w_exp_floor;

  logic        w_round_up;
  logic [23:0] w_frac_sum;
  logic [9:0]  w_rnd_exp;
  logic        w_rnd_inf;

  float_cmp u_cmp (
    .a     (r_a),
    .b     (r_b),
    .gt    (w_gt),
    .lt    (w_lt),
    .e_dif (w_edif)
  );

  // Ordering decisions taken in CMP: zero shortcut and capped align count.
  always_comb begin
    w_gt_zero  = (w_gt.exp == 8'd0);
    w_cnt_load = w_edif;
    if (32'(w_edif) > MAX_ALIGN) w_cnt_load = 8'(MAX_ALIGN);
  end

`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
  logic [27:0] w_lost_mask;

  // Whole alignment in one step; every shifted-out bit folds into sticky.
  always_comb begin
    w_align_done = 1'b1;
    w_lost_mask  = (28'd1 << r_cnt) - 28'd1;
    w_ml_aligned = (r_ml >> r_cnt) | {27'd0, |(r_ml & w_lost_mask)};
  end
`else
  // One-bit alignment step; the bit leaving position 0 folds into sticky.
  always_comb begin
    w_align_done = (r_cnt == 8'd0);
    w_ml_aligned = {1'b0, r_ml[27:2], r_ml[1] | r_ml[0]};
  end
`endif

  // Normalize conditions, checked in priority order zero / carry / low.
  always_comb begin
    w_norm_zero  = (r_mg == 28'd0);
    w_norm_carry = r_mg[27];
    w_norm_low   = ~r_mg[26];
    w_carry_ovf  = ((r_exp + 10'd1) >= 10'd255);
    w_exp_floor  = (r_exp <= 10'd1);
  end

  // Round-to-nearest-even; a carry out of the fraction means mantissa overflow.
  always_comb begin
    w_round_up = r_mg[2] & (r_mg[1] | r_mg[0] | r_mg[3]);
    w_frac_sum = {1'b0, r_mg[25:3]} + {23'd0, w_round_up};
    w_rnd_exp  = r_exp + {9'd0, w_frac_sum[23]};
    w_rnd_inf  = (w_rnd_exp >= 10'd255);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CMP;
      // A zero larger operand is routed through NORM's zero check, so the
      // +0 result appears two cycles after the accept.
      S_CMP:   w_next = w_gt_zero ? S_NORM : S_ALIGN;
      S_ALIGN: if (w_align_done) w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM: begin
        if (w_norm_zero)       w_next = S_DONE;
        else if (w_norm_carry) w_next = w_carry_ovf ? S_DONE : S_NORM;
        else if (w_norm_low)   w_next = w_exp_floor ? S_DONE : S_NORM;
        else                   w_next = S_ROUND;
      end
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    result    = r_result;
  end

  // Datapath: operand capture, align, add/sub, normalize and round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_mg     <= '0;
      r_ml     <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_sub    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_CMP: begin
          r_sign <= w_gt.sign;
          r_sub  <= w_gt.sign ^ w_lt.sign;
          r_exp  <= {2'b00, w_gt.exp};
          r_cnt  <= w_cnt_load;
          r_mg   <= w_gt_zero ? '0 : {2'b01, w_gt.mnt, 3'b000};
          r_ml   <= (w_lt.exp == 8'd0) ? '0 : {2'b01, w_lt.mnt, 3'b000};
        end
        S_ALIGN: begin
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
          r_ml  <= w_ml_aligned;
          r_cnt <= '0;
`else
          if (!w_align_done) begin
            r_ml  <= w_ml_aligned;
            r_cnt <= r_cnt - 8'd1;
          end
`endif
        end
        S_ADD: begin
          r_mg <= r_sub ? (r_mg - r_ml) : (r_mg + r_ml);
        end
        S_NORM: begin
          if (w_norm_zero) begin
            r_result <= '0;
          end else if (w_norm_carry) begin
            if (w_carry_ovf) begin
              r_result <= '{sign: r_sign, exp: 8'hFF, mnt: '0};
            end else begin
              r_mg  <= {1'b0, r_mg[27:2], r_mg[1] | r_mg[0]};
              r_exp <= r_exp + 10'd1;
            end
          end else if (w_norm_low) begin
            if (w_exp_floor) begin
              r_result <= '{sign: r_sign, exp: '0, mnt: '0};
            end else begin
              r_mg  <= {r_mg[26:0], 1'b0};
              r_exp <= r_exp - 10'd1;
            end
          end
        end
        S_ROUND: begin
          if (w_rnd_inf) r_result <= '{sign: r_sign, exp: 8'hFF, mnt: '0};
          else           r_result <= '{sign: r_sign, exp: w_rnd_exp[7:0], mnt: w_frac_sum[22:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed vector table, randomized
// operands against an integer-arithmetic reference model, and hand-written
// reset/handshake sequences.
module tb_fp_add_seq;
  import definitions::*;

  localparam int unsigned MAXA = 27;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  logic   in_valid = 1'b0;
  logic   out_ready = 1'b0;
  logic   in_ready, out_valid, busy;
  Float32 a_in = '0;
  Float32 b_in = '0;
  Float32 res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_add_seq #(.MAX_ALIGN(MAXA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (res),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;   // -1: latency not checked
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference: exact integer arithmetic on the flushed, ordered operands.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    logic [31:0] g, l;
    logic [7:0]  e8;
    int          ge, le, steps, e, nsh;
    longint unsigned lm, G, L, S, m, lost;
    if (x[30:0] >= y[30:0]) begin g = x; l = y; end
    else                    begin g = y; l = x; end
    ge  = int'(g[30:23]);
    le  = int'(l[30:23]);
    lat = -1;
    if (ge == 0) begin r = 32'h0; lat = 2; return; end
    lm    = (le == 0) ? 64'd0 : ((64'd1 << 23) | 64'(l[22:0]));
    steps = ge - le;
    if (steps > int'(MAXA)) steps = int'(MAXA);
    G    = ((64'd1 << 23) | 64'(g[22:0])) << 3;
    L    = lm << 3;
    lost = L & ((64'd1 << steps) - 64'd1);
    L    = (L >> steps) | ((lost != 0) ? 64'd1 : 64'd0);
    S    = (g[31] == l[31]) ? G + L : G - L;
    e    = ge;
    nsh  = 0;
    while (1) begin
      if (S == 0) begin r = 32'h0; return; end
      if (S >= (64'd1 << 27)) begin
        if (e + 1 >= 255) begin r = {g[31], 8'hFF, 23'd0}; return; end
        S = (S >> 1) | (S & 64'd1);
        e++;
        nsh++;
      end else if (S < (64'd1 << 26)) begin
        if (e <= 1) begin r = {g[31], 31'd0}; return; end
        S = S << 1;
        e--;
        nsh++;
      end else break;
    end
    m = S >> 3;
    if (S[2] && (S[1] || S[0] || m[0])) m = m + 1;
    if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e++; end
    e8 = 8'(e);
    if (e >= 255) r = {g[31], 8'hFF, 23'd0};
    else          r = {g[31], e8, m[22:0]};
    lat = 5 + (FAST ? 0 : steps) + nsh;
  endfunction

  // Present one operand pair and let it be accepted at the next rising edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a_in     = av;
    b_in     = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accept until out_valid, bounded.
  task automatic wait_valid(output int lat, output bit to);
    lat = 0;
    to  = 1'b0;
    while (1) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
      if (lat >= 300) begin to = 1'b1; break; end
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input int elat);
    int lat;
    bit to;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    issue(av, bv);
    wait_valid(lat, to);
    chk({nm, "_timeout"}, 32'(to), 32'd0);
    chk({nm, "_result"}, res, er);
    if (elat >= 0) chk({nm, "_latency"}, 32'(lat), 32'(elat));
    take();
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] x, y, mr, held;
    int          mlat, ea, eb, sel, lat;
    bit          to;

    vecs[0] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 6};
    vecs[1] = '{32'h3F800000, 32'hBF800000, 32'h00000000, -1};
    vecs[2] = '{32'h3FC00000, 32'hBFA00000, 32'h3E800000, 7};
    vecs[3] = '{32'h3F800000, 32'h30800000, 32'h3F800000, FAST ? 5 : 32};
    vecs[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, -1};
    vecs[5] = '{32'h00000000, 32'h00400000, 32'h00000000, 2};
    vecs[6] = '{32'h40000000, 32'h40000000, 32'h40800000, 6};
    vecs[7] = '{32'hBF800000, 32'hBF800000, 32'hC0000000, 6};

    // Reset state
    #1 rst_n = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", res, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);

    // Randomized operands against the model
    for (int i = 0; i < 300; i++) begin
      ea  = $urandom_range(1, 254);
      sel = $urandom_range(0, 9);
      if (sel == 8) ea = 254;
      if (sel == 9) ea = 255;
      x = {1'($urandom), 8'(ea), 23'($urandom)};
      case (sel)
        0:       y = {1'($urandom), 8'd0, 23'($urandom)};
        1:       y = {~x[31], x[30:0]};
        2:       y = {~x[31], x[30:3], 3'($urandom)};
        3:       y = {1'($urandom), 8'(ea), 23'($urandom)};
        default: begin
          eb = ea + $urandom_range(0, 40) - 20;
          if (eb < 0) eb = 0;
          if (eb > 255) eb = 255;
          y = {1'($urandom), 8'(eb), 23'($urandom)};
        end
      endcase
      if ($urandom_range(0, 1) == 1) begin mr = x; x = y; y = mr; end
      model(x, y, mr, mlat);
      run_op($sformatf("rnd%0d", i), x, y, mr, mlat);
    end

    // Reset pulse mid-operation aborts and the next op is clean
    issue(32'h3F800000, 32'h30800000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", 32'h40000000, 32'h40000000, 32'h40800000, 6);

    // Consumer stall: DONE holds, result stable, new operands ignored
    model(32'h40000000, 32'h3F800000, held, mlat);
    issue(32'h40000000, 32'h3F800000);
    wait_valid(lat, to);
    chk("stall_timeout", 32'(to), 32'd0);
    for (int k = 0; k < 10; k++) begin
      a_in     = 32'h3F800000;
      b_in     = 32'h3F800000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_result", k), res, held);
      chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    take();
    chk("after_take_in_ready", 32'(in_ready), 32'd1);
    chk("after_take_busy", 32'(busy), 32'd0);
    run_op("back2back", 32'h3FC00000, 32'hBFA00000, 32'h3E800000, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_seq.md
# fp_add_seq

Multi-cycle sequencer for single-precision floating-point addition. Accepts an operand pair `a`/`b` (Float32 from `definitions`) on a valid/ready handshake. Orders the operands with one `float_cmp` instance, then steps through align, add/subtract, normalize and round. Returns the Float32 sum on a second valid/ready handshake. One operation is in flight at a time; this is the adder front-end for the FP datapath.

## Interface
- `MAX_ALIGN`, default 27: cap on the alignment shift count. Shifts beyond the cap only feed sticky.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`, `b`  in  Float32  operands; captured on an accept.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  Float32  sum; stable while `out_valid` is high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Accept: `in_valid & in_ready` at a rising edge captures `a`/`b` and moves to CMP.
- Denormal flush: an input with exp == 0 is treated as zero. exp == 255 inputs are processed as ordinary numbers; there is no NaN/inf handling.
- Working mantissa: 28 bits = carry, hidden 1, 23 fraction bits, then guard/round/sticky.
- States and transitions:
  - IDLE → CMP on accept.
  - CMP: registers gt/lt/e_dif from `float_cmp`.
    - If gt exp == 0, result = +0 and go to DONE.
    - If lt exp == 0, lt mantissa = 0.
    - Otherwise load count = min(e_dif, MAX_ALIGN) and go to ALIGN.
  - ALIGN:
    - If count == 0, go to ADD.
    - Else shift the lt mantissa right by 1 (the shifted-out bit ORs into sticky), count−1, stay.
  - ADD: signs equal → gt + lt; signs differ → gt − lt. Result sign = gt sign. Go to NORM.
  - NORM, one action per cycle:
    - Mantissa == 0 → result +0, go to DONE.
    - Carry set → shift right 1 (sticky kept), exp+1.
    - Hidden bit clear → shift left 1, exp−1. If exp would drop below 1, result = signed zero and go to DONE.
    - Otherwise (normalized) → go to ROUND.
  - ROUND: round-to-nearest-even on G/R/S.
    - Mantissa overflow from rounding → mantissa 0, exp+1.
    - Go to DONE.
  - DONE: `out_valid` = 1. On `out_ready` go to IDLE.
- Overflow: an exponent reaching 255 in NORM or ROUND gives sign | exp 255 | mnt 0 (±inf), then go to DONE.
- Equal magnitude with opposite signs always gives +0 (0x00000000).

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `result` = 0x00000000; state is IDLE.
- Reset asserted in any state aborts the operation immediately. The in-flight operand pair is discarded.
- Latency from the accept edge to `out_valid` high = 5 + align_steps + norm_steps cycles:
  - align_steps = min(e_dif, MAX_ALIGN).
  - norm_steps = number of right or left shifts done in NORM.
  - The zero shortcut in CMP takes 2 cycles.
- `in_valid` is ignored outside IDLE. Back-to-back: the earliest next accept is the cycle after the DONE handshake.
- `out_ready` low holds DONE, `result` and `out_valid` indefinitely.

## Configuration
- `FP_ADD_SEQ_FAST_ALIGN_EN` defined:
  - ALIGN is a single-cycle barrel shift by count, with sticky = OR of all shifted-out bits.
  - align_steps = 0 always.
- Not defined: iterative 1-bit/cycle alignment as described in Operation.
- Numeric results are identical in both builds; only latency differs.

## Test plan
- 0x3F800000 + 0x3F800000 → `result` 0x40000000; `out_valid` 6 cycles after accept.
- 0x3F800000 + 0xBF800000 → 0x00000000; verify the NORM zero path.
- 0x3FC00000 + 0xBFA00000 → 0x3E800000 (two left shifts); latency 7.
- 0x3F800000 + 0x30800000 → 0x3F800000 (capped align, sticky rounds down). Latency 32 without the macro, 5 with it.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 (overflow to +inf).
- Reset and handshake:
  - Pulse `rst_n` low during ALIGN: `out_valid` goes to 0 and `in_ready` to 1 asynchronously, and the next op 0x40000000 + 0x40000000 returns 0x40800000.
  - Hold `out_ready` low for 10 cycles: `result` stays stable and `in_ready` stays 0.
